// File: rtl/network_mac_pipe.sv
// network_mac_pipe: pipelined multiply-accumulate for the CNN datapath.
// Multiplies din0 x din1 (each independently signed or unsigned) through a
// NUM_STAGE-deep multiplier pipe. It accumulates the products over a group
// framed by in_first/in_last. At the end of a group it rounds half-up, shifts
// right by FRAC_SHIFT and clamps the sum to the signed OUT_WIDTH range.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   ce         clock enable; every register holds while low
//   in_valid   din0/din1/in_first/in_last valid this cycle
//   in_first   sample opens a new accumulation group
//   in_last    sample closes the group and requests a result
//   din0       operand A (A_WIDTH bits)
//   din1       operand B (B_WIDTH bits)
//   out_valid  dout/sat carry a new result (one ce-qualified cycle)
//   dout       rounded, shifted, saturated group sum
//   sat        dout was clamped for this result
//
// Timing: a sample with in_last captured at ce-edge k raises out_valid after
// ce-edge k+NUM_STAGE+1. The pipe is: input register, NUM_STAGE-2 product
// registers, the accumulator, a rounding register, then the output register.
module network_mac_pipe #(
    parameter int unsigned A_WIDTH    = 16,
    parameter int unsigned B_WIDTH    = 13,
    parameter int unsigned A_SIGNED   = 1,
    parameter int unsigned B_SIGNED   = 0,
    parameter int unsigned NUM_STAGE  = 3,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned FRAC_SHIFT = 12,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned SATURATE   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
);

    localparam int unsigned PW  = A_WIDTH + B_WIDTH + 1;
    localparam int unsigned NP  = NUM_STAGE - 2;
    localparam int unsigned RW  = ACC_WIDTH + 1;
    localparam int unsigned HSH = (FRAC_SHIFT == 0) ? 0 : FRAC_SHIFT - 1;

    // Round-half-up bias. It is zero when there is no fractional shift.
    localparam logic signed [RW-1:0] HALF  = (FRAC_SHIFT == 0) ? RW'(0) : RW'(1) << HSH;
    localparam logic signed [RW-1:0] R_MAX = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] R_MIN = ~R_MAX;

    // Stage 1: input capture
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic               v1_q, f1_q, l1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            f1_q <= 1'b0;
            l1_q <= 1'b0;
        end else if (ce) begin
            a_q  <= din0;
            b_q  <= din1;
            v1_q <= in_valid;
            f1_q <= in_first;
            l1_q <= in_last;
        end
    end

    // Operand extension and signed multiply.
    // One spare bit keeps the mixed-signedness product exact.
    logic signed [PW-1:0] a_ext_c, b_ext_c, prod_c;

    always_comb begin
        a_ext_c = PW'(a_q);
        b_ext_c = PW'(b_q);
        if (A_SIGNED != 0) a_ext_c = PW'(signed'(a_q));
        if (B_SIGNED != 0) b_ext_c = PW'(signed'(b_q));
        prod_c = a_ext_c * b_ext_c;
    end

    // Product pipe, with the valid/first/last flags delayed alongside
    logic signed [PW-1:0] p_q [NP];
    logic [NP-1:0]        pv_q, pf_q, pl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NP); i++) p_q[i] <= '0;
            pv_q <= '0;
            pf_q <= '0;
            pl_q <= '0;
        end else if (ce) begin
            p_q[0]  <= prod_c;
            pv_q[0] <= v1_q;
            pf_q[0] <= f1_q;
            pl_q[0] <= l1_q;
            for (int i = 1; i < int'(NP); i++) begin
                p_q[i]  <= p_q[i-1];
                pv_q[i] <= pv_q[i-1];
                pf_q[i] <= pf_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
        end
    end

    // Accumulator: wraps modulo 2^ACC_WIDTH, and invalid slots leave it untouched
    logic signed [ACC_WIDTH-1:0] acc_q, p_ext_c;
    logic                        accl_q;

    assign p_ext_c = ACC_WIDTH'(p_q[NP-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            accl_q <= 1'b0;
        end else if (ce) begin
            accl_q <= pv_q[NP-1] & pl_q[NP-1];
            if (pv_q[NP-1]) begin
                acc_q <= pf_q[NP-1] ? p_ext_c : acc_q + p_ext_c;
            end
        end
    end

    // Rounding stage: the extra bit means adding the bias can never wrap
    logic signed [RW-1:0] acc_x_c, rnd_c, rnd_q;
    logic                 rndv_q;

    assign acc_x_c = RW'(acc_q);
    assign rnd_c   = (acc_x_c + HALF) >>> FRAC_SHIFT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd_q  <= '0;
            rndv_q <= 1'b0;
        end else if (ce) begin
            rnd_q  <= rnd_c;
            rndv_q <= accl_q;
        end
    end

    // Clamp to the signed output range
    logic [OUT_WIDTH-1:0] dout_c;
    logic                 sat_c;

    always_comb begin
        dout_c = rnd_q[OUT_WIDTH-1:0];
        sat_c  = 1'b0;
        if (SATURATE != 0) begin
            if (rnd_q > R_MAX) begin
                dout_c = R_MAX[OUT_WIDTH-1:0];
                sat_c  = 1'b1;
            end else if (rnd_q < R_MIN) begin
                dout_c = R_MIN[OUT_WIDTH-1:0];
                sat_c  = 1'b1;
            end
        end
    end

    // Output register: dout/sat hold between results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sat       <= 1'b0;
        end else if (ce) begin
            out_valid <= rndv_q;
            if (rndv_q) begin
                dout <= dout_c;
                sat  <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_network_mac_pipe.sv
// Directed bench for network_mac_pipe with default parameters.
// Each driven vector records any expected result, together with the ce-edge
// on which that result must appear. A monitor logs every new result.
// Both lists are compared at the end. Hand sequences cover reset and ce stalls.
module tb_network_mac_pipe;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, in_first, in_last;
    logic [15:0] din0;
    logic [12:0] din1;
    logic        out_valid;
    logic [15:0] dout;
    logic        sat;

    network_mac_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .dout      (dout),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          f;
        bit          l;
        logic [15:0] a;
        logic [12:0] b;
        bit          chk;
        logic [15:0] ed;
        bit          es;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        bit          s;
        int          e;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ce_edges = 0;
    int   last_e = -1;

    always @(posedge clk) if (ce) ce_edges <= ce_edges + 1;

    // Log each result once, tagged with the ce-edge that produced it
    always @(negedge clk) begin
        if (out_valid === 1'b1 && ce_edges != last_e) begin
            got_q.push_back('{d: dout, s: sat, e: ce_edges});
            last_e = ce_edges;
        end
    end

    function automatic vec_t mk(bit v, bit f, bit l, int a, int b, bit chk, int ed, bit es);
        vec_t r;
        r.v = v; r.f = f; r.l = l;
        r.a = 16'(a); r.b = 13'(b);
        r.chk = chk; r.ed = 16'(ed); r.es = es;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t t);
        in_valid = t.v;
        in_first = t.f;
        in_last  = t.l;
        din0     = t.a;
        din1     = t.b;
        if (t.chk && ce) exp_q.push_back('{d: t.ed, s: t.es, e: ce_edges + 1 + LAT});
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (n) step();
    endtask

    vec_t vt[19];
    bit   seen;

    initial begin
        vt[0]  = mk(1, 1, 1,   4096, 4096, 1,   4096, 0);
        vt[1]  = mk(1, 1, 1,     -3,   15, 1,      0, 0);
        vt[2]  = mk(1, 1, 1,      3, 2048, 1,      2, 0);
        vt[3]  = mk(1, 1, 1,     -3, 2048, 1,     -1, 0);
        vt[4]  = mk(1, 1, 0,   4096, 4096, 0,      0, 0);
        vt[5]  = mk(1, 0, 0,  -8192, 4096, 0,      0, 0);
        vt[6]  = mk(1, 0, 0,  12288, 4096, 0,      0, 0);
        vt[7]  = mk(1, 0, 1,   4096, 4096, 1,  12288, 0);
        vt[8]  = mk(1, 1, 0,   4096, 4096, 0,      0, 0);
        vt[9]  = mk(1, 0, 0,  -8192, 4096, 0,      0, 0);
        vt[10] = mk(0, 1, 1,    100,  100, 0,      0, 0);
        vt[11] = mk(1, 0, 0,  12288, 4096, 0,      0, 0);
        vt[12] = mk(1, 0, 1,   4096, 4096, 1,  12288, 0);
        vt[13] = mk(1, 1, 0,  32767, 8191, 0,      0, 0);
        vt[14] = mk(1, 0, 0,  32767, 8191, 0,      0, 0);
        vt[15] = mk(1, 0, 1,  32767, 8191, 1,  32767, 1);
        vt[16] = mk(1, 1, 0, -32768, 8191, 0,      0, 0);
        vt[17] = mk(1, 0, 0, -32768, 8191, 0,      0, 0);
        vt[18] = mk(1, 0, 1, -32768, 8191, 1, -32768, 1);

        reset = 1'b1;
        ce    = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        din0 = '0; din1 = '0;
        repeat (2) step();
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset dout", 64'(dout), 64'(0));
        check("reset sat", 64'(sat), 64'(0));
        reset = 1'b0;
        idle(2);

        // Table vectors: plain multiplies, rounding, groups, bubble, saturation
        for (int i = 0; i < 19; i++) drive(vt[i]);
        idle(10);

        // Reset mid-stream: clears outputs at once, and the in-flight sample is lost
        drive(mk(1, 1, 1, 4096, 4096, 0, 0, 0));
        idle(1);
        reset = 1'b1;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'(0));
        check("midreset dout", 64'(dout), 64'(0));
        check("midreset sat", 64'(sat), 64'(0));
        idle(2);
        reset = 1'b0;
        idle(8);

        // After reset, a valid sample without first adds to a cleared accumulator
        drive(mk(1, 0, 1, 4096, 4096, 1, 4096, 0));
        idle(8);

        // Back-to-back groups, with a 3-cycle ce stall while the first result is shown
        drive(mk(1, 1, 1, 4096, 4096, 1, 4096, 0));
        drive(mk(1, 1, 1, 8192, 4096, 1, 8192, 0));
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            else step();
        end
        check("stall wait out_valid", 64'(seen), 64'(1));
        check("stall first dout", 64'(dout), 64'(4096));
        ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            din0 = 16'(c + 7); din1 = 13'(c + 3); in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
            step();
            check($sformatf("stall%0d out_valid", c), 64'(out_valid), 64'(1));
            check($sformatf("stall%0d dout", c), 64'(dout), 64'(4096));
            check($sformatf("stall%0d sat", c), 64'(sat), 64'(0));
        end
        ce = 1'b1;
        idle(10);

        check("result count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("res%0d dout", i), 64'(got_q[i].d), 64'(exp_q[i].d));
                check($sformatf("res%0d sat", i), 64'(got_q[i].s), 64'(exp_q[i].s));
                check($sformatf("res%0d edge", i), 64'(got_q[i].e), 64'(exp_q[i].e));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
